// File: rtl/common_pkg.sv
// Shared geometry, row type, clear-FSM states and byte-enable merge for the row RAM.
package common_pkg;

  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned ROW_BYTES  = 16;
  localparam int unsigned ROW_BITS   = ROW_BYTES * 8;
  localparam int unsigned OFF_W      = $clog2(ROW_BYTES);
  localparam int unsigned LINE_W     = ADDR_WIDTH - OFF_W;
  localparam int unsigned LINES      = 1 << LINE_W;

  typedef logic [ROW_BITS-1:0] row_t;

  typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_e;

  // Replace the bytes selected by be with the corresponding bytes of new_row.
  function automatic row_t be_merge(input row_t old_row, input row_t new_row,
                                    input logic [ROW_BYTES-1:0] be);
    row_t r;
    r = old_row;
    for (int unsigned k = 0; k < ROW_BYTES; k++) begin
      if (be[k]) r[8*k +: 8] = new_row[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/row_ram_rd_pipe.sv
// Per-port read return pipeline: RD_LAT registered stages of valid + data.
module row_ram_rd_pipe
  import common_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid,
  input  row_t in_data,
  output logic out_valid,
  output row_t out_data
);

  logic [RD_LAT-1:0] vld_q;
  row_t              dat_q [RD_LAT];

  // Data registers only load on a valid beat so the port holds its last value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) dat_q[0] <= in_data;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/row_ram_mp.sv
// Multi-read, single-write row RAM with byte enables, write->read forwarding,
// hardware zero-clear sweep and sticky misalignment flag.
module row_ram_mp
  import common_pkg::*;
#(
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned RD_LAT      = 1,
  parameter bit          WRITE_FIRST = 1'b1,
  parameter string       INIT_FILE   = ""
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_RD-1:0]                  rd_en_i,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]  rd_addr_i,
  output logic [NUM_RD-1:0]                  rd_valid_o,
  output logic [NUM_RD-1:0][ROW_BITS-1:0]    rd_data_o,
  input  logic                               wr_en_i,
  input  logic [ADDR_WIDTH-1:0]              wr_addr_i,
  input  logic [ROW_BYTES-1:0]               wr_be_i,
  input  logic [ROW_BITS-1:0]                wr_data_i,
  input  logic                               clr_req_i,
  output logic                               clr_busy_o,
  output logic                               err_o
);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("row_ram_mp: RD_LAT must be 1 or 2");
  end

  row_t mem [LINES];

  clr_state_e        state_q, state_n;
  logic [LINE_W-1:0] cnt_q, cnt_n;
  logic              busy_q, err_q;

  logic              idle;
  logic              wr_acc;
  logic [LINE_W-1:0] wr_line;
  logic [NUM_RD-1:0] rd_acc;
  logic [NUM_RD-1:0] rd_mis;

  assign idle    = (state_q == CLR_IDLE);
  assign wr_acc  = wr_en_i & idle;
  assign wr_line = wr_addr_i[ADDR_WIDTH-1:OFF_W];
  assign rd_acc  = rd_en_i & {NUM_RD{idle}};

  // Clear sweep FSM: one line per cycle from 0 up to LINES-1.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req_i) begin
          state_n = CLR_SWEEP;
          cnt_n   = '0;
        end
      end
      CLR_SWEEP: begin
        cnt_n = cnt_q + LINE_W'(1);
        if (cnt_q == LINE_W'(LINES - 1)) state_n = CLR_IDLE;
      end
      default: state_n = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      busy_q  <= (state_n == CLR_SWEEP);
      err_q   <= err_q | (|rd_mis) | (wr_acc & (|wr_addr_i[OFF_W-1:0]));
    end
  end

  // Sweep has priority; host writes are locked out while it runs.
  always_ff @(posedge clk_i) begin
    if (state_q == CLR_SWEEP) begin
      mem[cnt_q] <= '0;
    end else if (wr_acc) begin
      mem[wr_line] <= be_merge(mem[wr_line], wr_data_i, wr_be_i);
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [LINE_W-1:0] rd_line;
    row_t              rd_raw;

    assign rd_line   = rd_addr_i[p][ADDR_WIDTH-1:OFF_W];
    assign rd_mis[p] = rd_acc[p] & (|rd_addr_i[p][OFF_W-1:0]);

    always_comb begin
      rd_raw = mem[rd_line];
      if (WRITE_FIRST && wr_acc && (wr_line == rd_line)) begin
        rd_raw = be_merge(mem[rd_line], wr_data_i, wr_be_i);
      end
    end

    row_ram_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .in_valid (rd_acc[p]),
      .in_data  (rd_raw),
      .out_valid(rd_valid_o[p]),
      .out_data (rd_data_o[p])
    );
  end

  assign clr_busy_o = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_row_ram_mp.sv
// Bench for row_ram_mp: two instances (RD_LAT=1/WRITE_FIRST=1, RD_LAT=2/WRITE_FIRST=0)
// share stimulus and are compared each cycle against a line-array reference model.
module tb_row_ram_mp;
  import common_pkg::*;

  localparam int unsigned NR = 2;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic [NR-1:0]                 rd_en;
  logic [NR-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic                          wr_en;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [ROW_BYTES-1:0]          wr_be;
  row_t                          wr_data;
  logic                          clr_req;

  logic [NR-1:0]                 vld0, vld1;
  logic [NR-1:0][ROW_BITS-1:0]   dat0, dat1;
  logic                          busy0, busy1, err0, err1;

  always #5 clk_i = ~clk_i;

  row_ram_mp #(.NUM_RD(NR), .RD_LAT(1), .WRITE_FIRST(1'b1)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_valid_o(vld0), .rd_data_o(dat0), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_be_i(wr_be), .wr_data_i(wr_data), .clr_req_i(clr_req),
    .clr_busy_o(busy0), .err_o(err0)
  );

  row_ram_mp #(.NUM_RD(NR), .RD_LAT(2), .WRITE_FIRST(1'b0)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_valid_o(vld1), .rd_data_o(dat1), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_be_i(wr_be), .wr_data_i(wr_data), .clr_req_i(clr_req),
    .clr_busy_o(busy1), .err_o(err1)
  );

  typedef struct {
    int   due;
    row_t data;
  } exp_t;

  row_t mem_m [LINES];
  int   clr_left;
  logic err_m;
  row_t last_m [2][NR];
  exp_t pend [2][NR][$];
  int   cyc;
  int   acc_rd;
  int   got_vld [2];
  int   n_checks;
  int   n_errors;

  task automatic check(input string tag, input logic [ROW_BITS-1:0] got,
                       input logic [ROW_BITS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic row_t merge_m(input row_t o, input row_t n, input logic [ROW_BYTES-1:0] be);
    row_t r;
    r = o;
    for (int k = 0; k < int'(ROW_BYTES); k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int k = 0; k < int'(ROW_BITS) / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic int line_of(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) / int'(ROW_BYTES)) % int'(LINES);
  endfunction

  task automatic set_idle();
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_be   = '0;
    wr_data = '0;
    clr_req = 1'b0;
  endtask

  task automatic check_outputs();
    logic [NR-1:0] v;
    row_t          dv;
    logic          b, e;
    for (int d = 0; d < 2; d++) begin
      b = (d == 0) ? busy0 : busy1;
      e = (d == 0) ? err0 : err1;
      for (int p = 0; p < int'(NR); p++) begin
        logic exp_v;
        v  = (d == 0) ? vld0 : vld1;
        dv = (d == 0) ? dat0[p] : dat1[p];
        exp_v = 1'b0;
        if (pend[d][p].size() > 0 && pend[d][p][0].due == cyc) begin
          exp_v = 1'b1;
          last_m[d][p] = pend[d][p][0].data;
          void'(pend[d][p].pop_front());
        end
        check($sformatf("d%0d_p%0d_valid", d, p), ROW_BITS'(v[p]), ROW_BITS'(exp_v));
        check($sformatf("d%0d_p%0d_data", d, p), dv, last_m[d][p]);
        if (v[p]) got_vld[d]++;
      end
      check($sformatf("d%0d_busy", d), ROW_BITS'(b), ROW_BITS'(clr_left > 0));
      check($sformatf("d%0d_err", d), ROW_BITS'(e), ROW_BITS'(err_m));
    end
  endtask

  // Apply current inputs to the model, advance one clock, compare.
  task automatic step();
    int   wl, rl;
    row_t old;
    if (clr_left > 0) begin
      mem_m[LINES - clr_left] = '0;
      clr_left--;
    end else begin
      wl = line_of(wr_addr);
      for (int p = 0; p < int'(NR); p++) begin
        if (rd_en[p]) begin
          rl  = line_of(rd_addr[p]);
          old = mem_m[rl];
          pend[0][p].push_back('{cyc + 1,
              (wr_en && wl == rl) ? merge_m(old, wr_data, wr_be) : old});
          pend[1][p].push_back('{cyc + 2, old});
          acc_rd++;
          if (int'(rd_addr[p]) % int'(ROW_BYTES) != 0) err_m = 1'b1;
        end
      end
      if (wr_en) begin
        mem_m[wl] = merge_m(mem_m[wl], wr_data, wr_be);
        if (int'(wr_addr) % int'(ROW_BYTES) != 0) err_m = 1'b1;
      end
      if (clr_req) clr_left = LINES;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    check_outputs();
  endtask

  // Assert reset between edges, check immediate effect, then release.
  task automatic apply_reset();
    set_idle();
    rst_i = 1'b1;
    #1;
    clr_left = 0;
    err_m    = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < int'(NR); p++) begin
        pend[d][p].delete();
        last_m[d][p] = '0;
      end
    check_outputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic do_write(input int line, input row_t d, input logic [ROW_BYTES-1:0] be);
    set_idle();
    wr_en   = 1'b1;
    wr_addr = ADDR_WIDTH'(line * int'(ROW_BYTES));
    wr_data = d;
    wr_be   = be;
    step();
  endtask

  task automatic do_read(input int p, input logic [ADDR_WIDTH-1:0] a);
    set_idle();
    rd_en[p]   = 1'b1;
    rd_addr[p] = a;
    step();
  endtask

  task automatic drain(input int n);
    set_idle();
    repeat (n) step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    acc_rd   = 0;
    got_vld  = '{0, 0};
    for (int i = 0; i < int'(LINES); i++) mem_m[i] = '0;
    set_idle();
    apply_reset();

    // Initial sweep gives a known all-zero memory.
    clr_req = 1'b1;
    step();
    drain(LINES + 2);

    // Full-row write then read-back.
    do_write(3, {ROW_BYTES{8'hA5}}, '1);
    do_read(0, ADDR_WIDTH'(3 * ROW_BYTES));
    drain(3);

    // Same-cycle write and read of one line.
    do_write(5, {ROW_BYTES/2{16'h1122}}, '1);
    set_idle();
    wr_en      = 1'b1;
    wr_addr    = ADDR_WIDTH'(5 * ROW_BYTES);
    wr_be      = ROW_BYTES'(1);
    wr_data    = {ROW_BYTES{8'hFF}};
    rd_en[1]   = 1'b1;
    rd_addr[1] = ADDR_WIDTH'(5 * ROW_BYTES);
    step();
    do_read(1, ADDR_WIDTH'(5 * ROW_BYTES));
    do_write(6, rand_row(), '0);
    drain(3);

    // Sweep with traffic attempted during it, then sample lines.
    set_idle();
    clr_req = 1'b1;
    step();
    for (int i = 0; i < int'(LINES); i++) begin
      rd_en   = NR'($urandom);
      rd_addr = {$urandom, $urandom};
      wr_en   = 1'b1;
      wr_be   = '1;
      wr_addr = ADDR_WIDTH'($urandom);
      wr_data = rand_row();
      clr_req = 1'($urandom);
      step();
    end
    drain(2);
    do_read(0, '0);
    do_read(1, ADDR_WIDTH'((LINES / 2) * ROW_BYTES));
    do_read(0, ADDR_WIDTH'((LINES - 1) * ROW_BYTES));
    drain(3);

    // Reset in the middle of a sweep leaves upper lines intact.
    do_write(LINES - 1, {ROW_BYTES{8'hC3}}, '1);
    do_write(0, {ROW_BYTES{8'h5A}}, '1);
    set_idle();
    clr_req = 1'b1;
    step();
    drain(LINES / 2);
    apply_reset();
    do_read(0, '0);
    do_read(1, ADDR_WIDTH'((LINES - 1) * ROW_BYTES));
    drain(3);

    // Misaligned access flags err, which stays set until reset.
    do_write(7, {ROW_BYTES/4{32'hDEAD_BEEF}}, '1);
    do_read(0, ADDR_WIDTH'(7 * ROW_BYTES + 1));
    do_read(1, ADDR_WIDTH'(2 * ROW_BYTES));
    do_write(2, rand_row(), '1);
    drain(3);
    apply_reset();

    // Random mixed traffic.
    for (int i = 0; i < 10000; i++) begin
      rd_en = NR'($urandom);
      for (int p = 0; p < int'(NR); p++) begin
        rd_addr[p] = ADDR_WIDTH'($urandom);
        if ($urandom_range(0, 7) != 0) rd_addr[p][OFF_W-1:0] = '0;
      end
      wr_en   = 1'($urandom);
      wr_addr = ADDR_WIDTH'($urandom);
      if ($urandom_range(0, 7) != 0) wr_addr[OFF_W-1:0] = '0;
      wr_be   = ROW_BYTES'($urandom);
      wr_data = rand_row();
      clr_req = ($urandom_range(0, 999) == 0);
      step();
    end
    drain(4);
    for (int d = 0; d < 2; d++)
      check($sformatf("d%0d_valid_count", d), ROW_BITS'(got_vld[d]), ROW_BITS'(acc_rd));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
